// File: rtl/gray_lut_sequencer.sv
// gray_lut_sequencer: owns a 256xOUT_W transform LUT, sequences its loading and streams gray pixels
// through a 2-stage pipeline. Build macro GRAY_LUT_CLAMP_EN saturates all results to SAT_MAX.
// state  | meaning
// BYPASS | out = gray*C_GAIN, no LUT loaded since reset
// RUN    | out = lut[gray]
// DRAIN  | input blocked until both pipeline stages are empty
// LOAD   | cfg words written to lut[0..255] in order
module gray_lut_sequencer #(
  parameter int C_GAIN = 2,
  parameter int OUT_W  = 16
`ifdef GRAY_LUT_CLAMP_EN
  , parameter logic [OUT_W-1:0] SAT_MAX = OUT_W'(4095)
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  input  logic             cfg_wr_en_i,
  input  logic [OUT_W-1:0] cfg_wr_data_i,
  output logic             cfg_busy_o,
  output logic             cfg_done_o,
  output logic             lut_valid_o,
  input  logic             pix_in_valid_i,
  output logic             pix_in_ready_o,
  input  logic [7:0]       pix_in_gray_i,
  output logic             pix_out_valid_o,
  input  logic             pix_out_ready_i,
  output logic [OUT_W-1:0] pix_out_gray_o
);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic             lut_valid_q, lut_valid_d;
  logic             done_q, done_d;
  logic             lut_mode_q, lut_mode_d;
  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_gray_q, s1_gray_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_gray_q, out_gray_d;
  logic             lut_we;
  logic             adv;
  logic             in_ready;
  logic [OUT_W-1:0] lut_q [256];
  logic [OUT_W-1:0] lut_rd;
  logic [OUT_W-1:0] lut_res;
  logic [OUT_W-1:0] byp_res;

  assign lut_rd = lut_q[s1_gray_q];

`ifdef GRAY_LUT_CLAMP_EN
  logic [OUT_W+1:0] byp_wide;
  assign byp_wide = (OUT_W+2)'(s1_gray_q) * (OUT_W+2)'(C_GAIN);
  assign byp_res  = (byp_wide > (OUT_W+2)'(SAT_MAX)) ? SAT_MAX : byp_wide[OUT_W-1:0];
  assign lut_res  = (lut_rd > SAT_MAX) ? SAT_MAX : lut_rd;
`else
  assign byp_res  = OUT_W'(s1_gray_q) * OUT_W'(C_GAIN);
  assign lut_res  = lut_rd;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lut_valid_d = lut_valid_q;
    lut_mode_d  = lut_mode_q;
    done_d      = 1'b0;
    lut_we      = 1'b0;
    case (state_q)
      ST_BYPASS, ST_RUN: begin
        if (cfg_start_i) begin
          state_d     = ST_DRAIN;
          lut_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !out_valid_q) begin
          state_d = ST_LOAD;
          addr_d  = 8'd0;
        end
      end
      ST_LOAD: begin
        if (cfg_start_i) begin
          addr_d = 8'd0;
        end else if (cfg_wr_en_i) begin
          lut_we = 1'b1;
          addr_d = addr_q + 8'd1;
          if (addr_q == 8'd255) begin
            state_d     = ST_RUN;
            done_d      = 1'b1;
            lut_valid_d = 1'b1;
            lut_mode_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_BYPASS;
    endcase
  end

  // Mode comes from lut_mode_q so pixels still draining after a RUN exit use the old table.
  always_comb begin
    adv         = !out_valid_q || pix_out_ready_i;
    in_ready    = adv && ((state_q == ST_BYPASS) || (state_q == ST_RUN));
    s1_valid_d  = s1_valid_q;
    s1_gray_d   = s1_gray_q;
    out_valid_d = out_valid_q;
    out_gray_d  = out_gray_q;
    if (adv) begin
      s1_valid_d  = pix_in_valid_i && in_ready;
      if (pix_in_valid_i && in_ready) begin
        s1_gray_d = pix_in_gray_i;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_gray_d = lut_mode_q ? lut_res : byp_res;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BYPASS;
      addr_q      <= 8'd0;
      lut_valid_q <= 1'b0;
      done_q      <= 1'b0;
      lut_mode_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_gray_q   <= 8'd0;
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lut_valid_q <= lut_valid_d;
      done_q      <= done_d;
      lut_mode_q  <= lut_mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_gray_q   <= s1_gray_d;
      out_valid_q <= out_valid_d;
      out_gray_q  <= out_gray_d;
    end
  end

  // LUT storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (lut_we) begin
      lut_q[addr_q] <= cfg_wr_data_i;
    end
  end

  assign cfg_busy_o      = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
  assign cfg_done_o      = done_q;
  assign lut_valid_o     = lut_valid_q;
  assign pix_in_ready_o  = in_ready;
  assign pix_out_valid_o = out_valid_q;
  assign pix_out_gray_o  = out_gray_q;

endmodule

// File: tb/tb_gray_lut_sequencer.sv
// Self-checking bench for gray_lut_sequencer: directed steps with randomized data against a
// queue-based reference model. Honours GRAY_LUT_CLAMP_EN like the design.
module tb_gray_lut_sequencer;
  localparam int OUT_W   = 16;
  localparam int C_GAIN  = 2;
  localparam int SAT_MAX = 4095;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cfg_start_i, cfg_wr_en_i;
  logic [OUT_W-1:0] cfg_wr_data_i;
  logic             cfg_busy_o, cfg_done_o, lut_valid_o;
  logic             pix_in_valid_i, pix_in_ready_o;
  logic [7:0]       pix_in_gray_i;
  logic             pix_out_valid_o, pix_out_ready_i;
  logic [OUT_W-1:0] pix_out_gray_o;

  always #5 clk_i = ~clk_i;

  gray_lut_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_start_i(cfg_start_i), .cfg_wr_en_i(cfg_wr_en_i), .cfg_wr_data_i(cfg_wr_data_i),
    .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .lut_valid_o(lut_valid_o),
    .pix_in_valid_i(pix_in_valid_i), .pix_in_ready_o(pix_in_ready_o), .pix_in_gray_i(pix_in_gray_i),
    .pix_out_valid_o(pix_out_valid_o), .pix_out_ready_i(pix_out_ready_i),
    .pix_out_gray_o(pix_out_gray_o)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [15:0]      m_lut [256];
  logic [15:0]      ld_data [256];
  bit               m_active;
  logic [15:0]      exp_q [$];
  bit               stall_prev;
  logic [15:0]      stall_gray;
  bit               last_acc;

  function automatic logic [15:0] ref_val(input int g);
    int v;
    if (m_active) v = int'(m_lut[g]);
    else          v = (g * C_GAIN) % 65536;
`ifdef GRAY_LUT_CLAMP_EN
    if (v > SAT_MAX) v = SAT_MAX;
`endif
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at posedge+1, observe at posedge+2, return at next posedge+1.
  task automatic tick(input logic iv, input logic [7:0] g, input logic ordy,
                      input logic st, input logic we, input logic [15:0] wd);
    pix_in_valid_i  = iv;
    pix_in_gray_i   = g;
    pix_out_ready_i = ordy;
    cfg_start_i     = st;
    cfg_wr_en_i     = we;
    cfg_wr_data_i   = wd;
    #1;
    if (stall_prev) begin
      chk("hold_valid", pix_out_valid_o, 1);
      chk("hold_gray", pix_out_gray_o, stall_gray);
    end
    last_acc = iv && pix_in_ready_o;
    if (last_acc) exp_q.push_back(ref_val(g));
    if (pix_out_valid_o && ordy) begin
      if (exp_q.size() == 0) chk("out_unexpected", pix_out_valid_o, 0);
      else chk("pix_out", pix_out_gray_o, exp_q.pop_front());
    end
    stall_prev = pix_out_valid_o && !ordy;
    stall_gray = pix_out_gray_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'd0, 1, 0, 0, 16'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    pix_in_valid_i = 0; pix_out_ready_i = 1; cfg_start_i = 0; cfg_wr_en_i = 0;
    m_active = 0;
    exp_q.delete();
    stall_prev = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_out_valid", pix_out_valid_o, 0);
    chk("rst_out_gray", pix_out_gray_o, 0);
    chk("rst_lut_valid", lut_valid_o, 0);
    chk("rst_busy", cfg_busy_o, 0);
    chk("rst_done", cfg_done_o, 0);
    chk("rst_in_ready", pix_in_ready_o, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic begin_load();
    tick(0, 8'd0, 1, 1, 0, 16'd0);
    idle(3);
    chk("load_busy", cfg_busy_o, 1);
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) begin
      chk("done_early", cfg_done_o, 0);
      tick(0, 8'd0, 1, 0, 1, ld_data[i]);
      m_lut[i] = ld_data[i];
    end
  endtask

  task automatic finish_load();
    m_active = 1;
    chk("cfg_done", cfg_done_o, 1);
    chk("lut_valid_set", lut_valid_o, 1);
    chk("busy_after_load", cfg_busy_o, 0);
    idle(1);
    chk("done_pulse_width", cfg_done_o, 0);
  endtask

  task automatic send_list(input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] g2);
    tick(1, g0, 1, 0, 0, 16'd0);
    tick(1, g1, 1, 0, 0, 16'd0);
    tick(1, g2, 1, 0, 0, 16'd0);
    idle(3);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    logic [7:0] g, ga, gb;
    logic iv;

    // Test 1: bypass after reset, 2-cycle latency
    do_reset();
    tick(1, 8'd0, 1, 0, 0, 16'd0);
    chk("lat_not_yet", pix_out_valid_o, 0);
    tick(1, 8'd100, 1, 0, 0, 16'd0);
    chk("lat_two", pix_out_valid_o, 1);
    chk("lat_two_gray", pix_out_gray_o, 0);
    tick(1, 8'd255, 1, 0, 0, 16'd0);
    idle(3);
    chk("t1_lut_valid", lut_valid_o, 0);
    chk("t1_drained", exp_q.size(), 0);

    // Test 2: load i*3
    begin_load();
    for (int i = 0; i < 256; i++) ld_data[i] = 16'(i * 3);
    do_writes(256);
    finish_load();
    send_list(8'd10, 8'd255, 8'($urandom));
    for (int i = 0; i < 20; i++) tick(1, 8'($urandom), 1, 0, 0, 16'd0);
    idle(3);

    // Test 3: stall in flight, then reload
    ga = 8'($urandom); gb = 8'($urandom);
    tick(1, ga, 0, 0, 0, 16'd0);
    tick(1, gb, 0, 0, 0, 16'd0);
    tick(1, 8'd1, 0, 1, 0, 16'd0);
    pix_out_ready_i = 1;
    #1;
    chk("drain_in_ready", pix_in_ready_o, 0);
    chk("drain_busy", cfg_busy_o, 1);
    chk("drain_lut_valid", lut_valid_o, 0);
    for (int i = 0; i < 3; i++) tick(1, 8'd1, 0, 1, 1, 16'hDEAD);
    tick(1, 8'd1, 1, 0, 0, 16'd0);
    tick(1, 8'd1, 1, 0, 0, 16'd0);
    idle(3);
    chk("t3_delivered", exp_q.size(), 0);
    for (int i = 0; i < 256; i++) ld_data[i] = 16'($urandom);
    do_writes(256);
    finish_load();
    send_list(8'd0, 8'($urandom), 8'd255);

    // Test 4: random throttling over 1000 pixels
    sent = 0; cyc = 0;
    g = 8'($urandom);
    while (sent < 1000 && cyc < 20000) begin
      iv = ($urandom_range(3) != 0);
      tick(iv, g, ($urandom_range(2) != 0), 0, 0, 16'd0);
      if (last_acc) begin
        sent++;
        g = 8'($urandom);
      end
      cyc++;
    end
    chk("t4_sent", sent, 1000);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      idle(1);
      cyc++;
    end
    chk("t4_no_loss", exp_q.size(), 0);

    // Test 5a: restart after 100 writes (same-cycle write dropped), then full load
    begin_load();
    for (int i = 0; i < 256; i++) ld_data[i] = 16'($urandom);
    do_writes(100);
    tick(0, 8'd0, 1, 1, 1, 16'hBEEF);
    chk("restart_no_done", cfg_done_o, 0);
    for (int i = 0; i < 256; i++) ld_data[i] = 16'($urandom);
    do_writes(256);
    finish_load();
    send_list(8'd0, 8'd128, 8'd255);

    // Test 5b: restart then reset mid-load
    begin_load();
    do_writes(100);
    tick(0, 8'd0, 1, 1, 0, 16'd0);
    do_writes(50);
    chk("midload_no_done", cfg_done_o, 0);
    do_reset();
    send_list(8'd7, 8'd200, 8'($urandom));

    // Test 6: saturating LUT word
    begin_load();
    for (int i = 0; i < 256; i++) ld_data[i] = 16'($urandom);
    ld_data[200] = 16'hFFFF;
    do_writes(256);
    finish_load();
    send_list(8'd200, 8'd199, 8'd201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
